// File: rtl/secded_decoder.sv
// secded_decoder
//   Two-stage pipelined SECDED (39,32) decoder with valid/ready handshake on
//   both sides and saturating error statistics.
//
//   Codeword layout: bit 0 is overall even parity over bits 38:0, and bits
//   1..38 are Hamming positions. Check bits sit at 1,2,4,8,16,32. Data d0..d31
//   fill the remaining positions in ascending order.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake, in_code is the received 39-bit codeword
//   out_valid/out_ready output handshake
//   out_data          corrected data (uncorrected extraction on DED)
//   out_sec, out_ded  single-error-corrected / double-error-detected flags
//   out_syndrome      Hamming syndrome of the word
//   cnt_clear         synchronous clear of counters and sticky flag
//   sec_count, ded_count  saturating event counters (CNT_W bits)
//   ded_sticky        set by any DED transfer, held until cnt_clear
module secded_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [38:0]      in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [5:0]       out_syndrome,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count,
  output logic             ded_sticky
);

  logic        s1_valid;
  logic [38:0] s1_code;
  logic [5:0]  s1_syn;
  logic        s1_par;

  logic [5:0]  syn_c;
  logic        par_c;
  logic [38:0] fixed_c;
  logic [31:0] data_c;
  logic        sec_c;
  logic        ded_c;

  logic        in_acc;
  logic        s2_load;
  logic        out_xfer;

  // A stage advances when its successor is empty or draining this cycle.
  assign in_ready = !out_valid || out_ready || !s1_valid;
  assign in_acc   = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign out_xfer = out_valid && out_ready;

  // Stage 1 combinational: syndrome and overall parity of the raw codeword.
  always_comb begin
    syn_c = '0;
    for (int i = 1; i < 39; i++) begin
      if (in_code[i]) syn_c = syn_c ^ 6'(i);
    end
    par_c = ^in_code;
  end

  // Stage 2 combinational: classification and correction.
  always_comb begin
    fixed_c = s1_code;
    sec_c   = 1'b0;
    ded_c   = 1'b0;
    if (s1_par) begin
      if (s1_syn == 6'd0) begin
        // Only the overall parity bit flipped; data is untouched.
        sec_c = 1'b1;
      end else if (s1_syn <= 6'd38) begin
        sec_c   = 1'b1;
        fixed_c = s1_code ^ (39'(1) << s1_syn);
      end else begin
        // Odd parity but syndrome points outside the codeword.
        ded_c = 1'b1;
      end
    end else if (s1_syn != 6'd0) begin
      ded_c = 1'b1;
    end
    data_c = {fixed_c[38:33], fixed_c[31:17], fixed_c[15:9],
              fixed_c[7:5], fixed_c[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else begin
      if (in_acc) begin
        s1_valid <= 1'b1;
        s1_code  <= in_code;
        s1_syn   <= syn_c;
        s1_par   <= par_c;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else begin
      if (s2_load) begin
        out_valid    <= 1'b1;
        out_data     <= data_c;
        out_sec      <= sec_c;
        out_ded      <= ded_c;
        out_syndrome <= s1_syn;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Statistics count delivered words; a clear in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count  <= '0;
      ded_count  <= '0;
      ded_sticky <= 1'b0;
    end else if (cnt_clear) begin
      sec_count  <= '0;
      ded_count  <= '0;
      ded_sticky <= 1'b0;
    end else if (out_xfer) begin
      if (out_sec && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
      if (out_ded && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
      if (out_ded) ded_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_decoder.sv
module tb_secded_decoder;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [38:0]      in_code;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_sec;
  logic             out_ded;
  logic [5:0]       out_syndrome;
  logic             cnt_clear;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;
  logic             ded_sticky;

  int total = 0;
  int bad   = 0;

  secded_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syndrome(out_syndrome),
    .cnt_clear(cnt_clear), .sec_count(sec_count), .ded_count(ded_count),
    .ded_sticky(ded_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] c;
    logic [5:0]  s;
    int k;
    c = '0;
    k = 0;
    for (int i = 1; i < 39; i++) begin
      if (!is_pow2(i)) begin
        c[i] = d[k];
        k++;
      end
    end
    s = '0;
    for (int i = 1; i < 39; i++) if (c[i]) s = s ^ 6'(i);
    for (int j = 0; j < 6; j++) c[1 << j] = s[j];
    c[0] = ^c[38:1];
    return c;
  endfunction

  function automatic logic [31:0] extract(input logic [38:0] c);
    logic [31:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < 39; i++) begin
      if (!is_pow2(i)) begin
        d[k] = c[i];
        k++;
      end
    end
    return d;
  endfunction

  // Sends one word into an idle pipeline with out_ready high and returns the
  // output fields plus the latency in cycles (acceptance edge counts as 1).
  // Entered and left at posedge+1.
  task automatic decode_one(input logic [38:0] code, output logic [31:0] d,
                            output logic sec, output logic ded,
                            output logic [5:0] syn, output int lat);
    in_code   = code;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d   = out_data;
    sec = out_sec;
    ded = out_ded;
    syn = out_syndrome;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    #23;
    total++;
    if ({out_valid, out_sec, out_ded, out_data, out_syndrome} !== 41'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b sec=%b ded=%b data=%h syn=%0d expected all zero",
               out_valid, out_sec, out_ded, out_data, out_syndrome);
    end
    total++;
    if ({sec_count, ded_count, ded_sticky} !== '0) begin
      bad++;
      $display("FAIL reset_counters: got sec=%0d ded=%0d sticky=%b expected 0",
               sec_count, ded_count, ded_sticky);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_clean();
    logic [31:0] d;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    decode_one(39'h0, d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'd0, 1'b0, 1'b0, 6'd0} || lat != 2) begin
      bad++;
      $display("FAIL clean_zero: got data=%h sec=%b ded=%b syn=%0d lat=%0d expected 0/0/0/0 lat=2",
               d, sec, ded, syn, lat);
    end
    decode_one(39'h0F, d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'd1, 1'b0, 1'b0, 6'd0} || lat != 2) begin
      bad++;
      $display("FAIL clean_one: got data=%h sec=%b ded=%b syn=%0d lat=%0d expected 1/0/0/0 lat=2",
               d, sec, ded, syn, lat);
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    decode_one(39'h2F, d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'd1, 1'b1, 1'b0, 6'd5}) begin
      bad++;
      $display("FAIL single_bit5: got data=%h sec=%b ded=%b syn=%0d expected 1/1/0/5",
               d, sec, ded, syn);
    end
    total++;
    if (sec_count !== 4'd1) begin
      bad++;
      $display("FAIL single_count1: got %0d expected 1", sec_count);
    end
    decode_one(39'h0E, d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'd1, 1'b1, 1'b0, 6'd0}) begin
      bad++;
      $display("FAIL single_bit0: got data=%h sec=%b ded=%b syn=%0d expected 1/1/0/0",
               d, sec, ded, syn);
    end
    total++;
    if (sec_count !== 4'd2) begin
      bad++;
      $display("FAIL single_count2: got %0d expected 2", sec_count);
    end
  endtask

  task automatic test_double();
    logic [31:0] d;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    // Positions 5 (d1) and 9 (d4) flipped: raw extraction gives 1^2^16.
    decode_one(39'h22F, d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'h13, 1'b0, 1'b1, 6'd12}) begin
      bad++;
      $display("FAIL double_5_9: got data=%h sec=%b ded=%b syn=%0d expected 13/0/1/12",
               d, sec, ded, syn);
    end
    total++;
    if ({ded_count, ded_sticky, sec_count} !== {4'd1, 1'b1, 4'd2}) begin
      bad++;
      $display("FAIL double_stats: got ded=%0d sticky=%b sec=%0d expected 1/1/2",
               ded_count, ded_sticky, sec_count);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] d, base;
    logic [38:0] c, code;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    int nbad_single, nbad_double;
    nbad_single = 0;
    nbad_double = 0;
    for (int i = 0; i < 39; i++) begin
      base = $urandom;
      c    = encode(base);
      code = c ^ (39'(1) << i);
      decode_one(code, d, sec, ded, syn, lat);
      total++;
      if ({d, sec, ded, syn} !== {base, 1'b1, 1'b0, 6'(i)}) begin
        bad++;
        nbad_single++;
        if (nbad_single < 5)
          $display("FAIL sweep_single pos=%0d: got data=%h sec=%b ded=%b syn=%0d expected %h/1/0/%0d",
                   i, d, sec, ded, syn, base, i);
      end
    end
    for (int i = 0; i < 39; i++) begin
      base = $urandom;
      c    = encode(base);
      for (int j = i + 1; j < 39; j++) begin
        code = c ^ (39'(1) << i) ^ (39'(1) << j);
        decode_one(code, d, sec, ded, syn, lat);
        total++;
        if ({d, sec, ded, syn} !== {extract(code), 1'b0, 1'b1, 6'(i ^ j)}) begin
          bad++;
          nbad_double++;
          if (nbad_double < 5)
            $display("FAIL sweep_double pos=%0d,%0d: got data=%h sec=%b ded=%b syn=%0d expected %h/0/1/%0d",
                     i, j, d, sec, ded, syn, extract(code), i ^ j);
        end
      end
    end
    total++;
    if ({sec_count, ded_count} !== {4'd15, 4'd15}) begin
      bad++;
      $display("FAIL sweep_saturated: got sec=%0d ded=%0d expected 15/15", sec_count, ded_count);
    end
  endtask

  task automatic test_clear_collision();
    in_code   = encode(32'h0000_00A5) ^ (39'(1) << 3) ^ (39'(1) << 7);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_ded, ded_sticky} !== 3'b111) begin
      bad++;
      $display("FAIL clear_pre: got v=%b ded=%b sticky=%b expected 1/1/1", out_valid, out_ded, ded_sticky);
    end
    cnt_clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    total++;
    if ({ded_count, sec_count, ded_sticky, out_valid} !== 10'd0) begin
      bad++;
      $display("FAIL clear_collision: got ded=%0d sec=%0d sticky=%b v=%b expected 0/0/0/0",
               ded_count, sec_count, ded_sticky, out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    for (int n = 1; n <= 20; n++) begin
      decode_one(encode(32'(n * 7919)) ^ (39'(1) << (n % 39)), d, sec, ded, syn, lat);
      total++;
      if (sec_count !== 4'(n > 15 ? 15 : n)) begin
        bad++;
        $display("FAIL saturation n=%0d: got %0d expected %0d", n, sec_count, n > 15 ? 15 : n);
      end
    end
    total++;
    if ({ded_count, ded_sticky} !== 5'd0) begin
      bad++;
      $display("FAIL saturation_ded: got ded=%0d sticky=%b expected 0/0", ded_count, ded_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bp_data [8];
    logic [38:0] bp_code [8];
    logic [31:0] held;
    int idx_in, idx_out, cyc, occ;
    bit stall_prev;
    for (int k = 0; k < 8; k++) begin
      bp_data[k] = 32'h5A5A_0000 ^ (32'(k) * 32'h0101_0101);
      bp_code[k] = encode(bp_data[k]) ^ ((k % 2 == 1) ? (39'(1) << (k * 3 + 1)) : 39'd0);
    end
    idx_in = 0;
    idx_out = 0;
    cyc = 0;
    stall_prev = 1'b0;
    held = '0;
    while (idx_out < 8 && cyc < 100) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (idx_in < 8);
      in_code   = bp_code[idx_in < 8 ? idx_in : 7];
      #1;
      occ = idx_in - idx_out;
      total++;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        bad++;
        $display("FAIL bp_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, !(occ == 2 && !out_ready));
      end
      if (stall_prev) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL bp_stable cyc=%0d: got v=%b data=%h expected 1/%h", cyc, out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (out_data !== bp_data[idx_out]) begin
          bad++;
          $display("FAIL bp_order idx=%0d: got %h expected %h", idx_out, out_data, bp_data[idx_out]);
        end
        idx_out++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) idx_in++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (idx_out != 8) begin
      bad++;
      $display("FAIL bp_count: got %0d words expected 8", idx_out);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic sec, ded;
    logic [5:0] syn;
    int lat;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = encode(32'h1111_2222);
    @(posedge clk); #1;
    in_code = encode(32'h3333_4444);
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_full: got v=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, sec_count, ded_count, ded_sticky} !== 10'd0) begin
      bad++;
      $display("FAIL rst_mid_async: got v=%b sec=%0d ded=%0d sticky=%b expected all 0",
               out_valid, sec_count, ded_count, ded_sticky);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_after: got in_ready=%b v=%b expected 1/0", in_ready, out_valid);
    end
    decode_one(encode(32'hCAFE_F00D) ^ (39'(1) << 20), d, sec, ded, syn, lat);
    total++;
    if ({d, sec, ded, syn} !== {32'hCAFE_F00D, 1'b1, 1'b0, 6'd20} || lat != 2) begin
      bad++;
      $display("FAIL rst_mid_next: got data=%h sec=%b ded=%b syn=%0d lat=%0d expected cafef00d/1/0/20 lat=2",
               d, sec, ded, syn, lat);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_sweep();
    test_clear_collision();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secded_decoder.md
Name: secded_decoder

Overview:
- Pipelined SECDED (39,32) decoder.
- Consumes the 39-bit codeword from the error-injection stage and delivers corrected 32-bit data downstream.
- Flags each word as clean, single-error-corrected, or double-error-detected, and keeps saturating error statistics for the TMR fault-campaign bench.
- valid/ready handshake on both sides.

Parameters:
- CNT_W, 16, width of the SEC and DED event counters (saturating).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_code is valid
- in_ready  output  1  decoder can accept a word this cycle
- in_code  input  39  received codeword (error_in_enc_data)
- out_valid  output  1  out_* fields are valid
- out_ready  input  1  downstream accepts the word this cycle
- out_data  output  32  corrected data
- out_sec  output  1  single error was corrected
- out_ded  output  1  uncorrectable error detected
- out_syndrome  output  6  Hamming syndrome of the word
- cnt_clear  input  1  synchronous clear of the counters and the sticky flag
- sec_count  output  CNT_W  number of words with out_sec=1
- ded_count  output  CNT_W  number of words with out_ded=1
- ded_sticky  output  1  set on any DED and held until cnt_clear

Behaviour:
- Codeword format (fixed, shared with the encoder):
  - Bit 0 is overall even parity over bits 38:0.
  - Bits 1..38 are Hamming positions.
  - Check bits sit at positions 1, 2, 4, 8, 16, 32.
  - Data bits d0..d31 fill positions 3,5,6,7,9..15,17..31,33..38 in ascending order.
- Syndrome s[5:0]: XOR of the indices i (1..38) where in_code[i]=1.
- Overall parity p: XOR of all 39 bits.
- Classification:
  - s=0, p=0: clean.
  - s=0, p=1: bit 0 flipped. SEC, data unchanged.
  - s!=0, p=1, s<=38: flip position s, then SEC.
  - s!=0, p=1, s>38: DED (invalid position).
  - s!=0, p=0: DED.
- On DED, out_data carries the uncorrected extracted data bits.
- Pipeline, two stages:
  - S1 registers the codeword, s and p.
  - S2 registers the corrected data and flags.
  - Latency is exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
  - Full throughput is 1 word/cycle.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - in_ready = !s2_valid || out_ready || !s1_valid, i.e. a stage advances when its successor is empty or is draining.
  - While out_valid=1 && out_ready=0, out_* are held stable and in_ready drops once both stages are full.
  - No word is dropped or duplicated.
- Counters:
  - Increment once per word at output transfer (out_valid && out_ready).
  - Saturate at all-ones.
  - ded_sticky sets at the same event.
  - cnt_clear has priority over a simultaneous increment: the result is 0, the event is lost, and the sticky flag is cleared.
- Reset (asynchronous):
  - Both stage valids go to 0; out_valid, out_sec, out_ded go to 0.
  - out_data and out_syndrome go to 0; counters and ded_sticky go to 0.
  - in_ready goes to 1 after reset deassertion.
  - A reset mid-transfer discards in-flight words.
- out_sec and out_ded are never both 1.
- Flags are meaningful only while out_valid=1.

Test Plan:
- Clean words: data 0 → codeword 39'h0; data 1 → codeword 39'h0F. In both cases out_data equals the data, out_sec=0, out_ded=0, and out_valid rises 2 cycles after acceptance.
- Single errors: 39'h0F with bit 5 flipped (39'h2F) → out_data=1, out_sec=1, out_syndrome=5, sec_count=1. Flipping bit 0 (39'h0E) → out_data=1, out_sec=1, out_syndrome=0.
- Double errors: 39'h0F with bits 5 and 9 flipped → out_ded=1, out_sec=0, out_syndrome=12, ded_count=1, ded_sticky=1. Exhaustive sweep of all 39 single flips and all 741 double flips on random data → 100% SEC/DED classification.
- Backpressure: stream of 8 words with out_ready toggling 1,0,0,1 → all 8 delivered in order, out_* stable while stalled, in_ready=0 whenever both stages are full.
- Saturation and clear: CNT_W=4 with 20 single-error words → sec_count stops at 15. Assert cnt_clear in the same cycle as a DED transfer → ded_count=0 and ded_sticky=0 the next cycle.
- Reset mid-stream: assert rst_n=0 asynchronously with both stages full → out_valid=0 immediately, counters 0, and the next word decodes correctly with latency 2.
